// File: rtl/rr_mux4to1.sv
// 4-to-1 round-robin stream merger with a single registered output stage tagged by source index.
// Optional feature: define RRMUX_LAST_LOCK_EN to keep a channel's packet contiguous until its in_last beat.
module rr_mux4to1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
`ifdef RRMUX_LAST_LOCK_EN
  input  logic [3:0]         in_last,
  output logic               out_last,
`endif
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0] last_gnt;
  logic [1:0] grant;
  logic [1:0] idx;
  logic       grant_valid;
  logic       load;
`ifdef RRMUX_LAST_LOCK_EN
  logic       locked;
`endif

  assign load = !out_valid || out_ready;

  // Scan from the farthest offset back to last_gnt+1 so the nearest requester overwrites the rest.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 2'd0;
    idx         = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = last_gnt + 2'(k + 1);
      if (in_valid[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
`ifdef RRMUX_LAST_LOCK_EN
    if (locked) begin
      grant       = last_gnt;
      grant_valid = in_valid[last_gnt];
    end
`endif
  end

  always_comb begin
    in_ready = 4'b0000;
    if (!rst && load && grant_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'b00;
      last_gnt  <= 2'b11;
`ifdef RRMUX_LAST_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
`endif
    end else if (load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
        out_sel   <= grant;
        last_gnt  <= grant;
`ifdef RRMUX_LAST_LOCK_EN
        out_last  <= in_last[grant];
        locked    <= !in_last[grant];
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4to1.sv
// Self-checking bench for rr_mux4to1: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural round-robin model.
module tb_rr_mux4to1;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;
`ifdef RRMUX_LAST_LOCK_EN
  logic [3:0]         in_last;
  logic               out_last;
`endif

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  // Behavioural model: pointer, held beat and lock flag as plain integers.
  int mPtr = 3;
  bit mValid = 1'b0;
  int mData = 0;
  int mSel = 0;
  bit mLast = 1'b0;
  bit mLocked = 1'b0;
  logic [3:0] fired = 4'b0000;

  rr_mux4to1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef RRMUX_LAST_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Channel the model would hand the register to this cycle, or -1 for none.
  function automatic int modelGrant();
    if (rst) return -1;
    if (mValid && !out_ready) return -1;
`ifdef RRMUX_LAST_LOCK_EN
    if (mLocked) return in_valid[mPtr] ? mPtr : -1;
`endif
    for (int k = 1; k <= 4; k++) begin
      if (in_valid[(mPtr + k) % 4]) return (mPtr + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = modelGrant();
    fired = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    if (rst) begin
      mPtr = 3; mValid = 0; mData = 0; mSel = 0; mLast = 0; mLocked = 0;
    end else if (!mValid || out_ready) begin
      if (g >= 0) begin
        mValid = 1;
        mData  = int'(in_data[g*WIDTH +: WIDTH]);
        mSel   = g;
        mPtr   = g;
`ifdef RRMUX_LAST_LOCK_EN
        mLast   = in_last[g];
        mLocked = !in_last[g];
`endif
      end else begin
        mValid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    if (checkEn) begin
      g = modelGrant();
      checkOutput("model in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
      checkOutput("model out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("model out_data", 32'(out_data), 32'(mData));
      checkOutput("model out_sel", 32'(out_sel), 32'(mSel));
`ifdef RRMUX_LAST_LOCK_EN
      checkOutput("model out_last", 32'(out_last), 32'(mLast));
`endif
    end
  end

  // Random traffic that respects the hold-while-waiting rule for every channel.
  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      if (!(in_valid[i] && !fired[i])) begin
        in_valid[i] = ($urandom_range(0, 9) < 6);
        in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
`ifdef RRMUX_LAST_LOCK_EN
        in_last[i] = ($urandom_range(0, 2) == 0);
`endif
      end
    end
    out_ready = ($urandom_range(0, 9) < 7);
    rst = ($urandom_range(0, 99) == 0);
  endtask

  int sparseExp[4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1;
    in_valid = 4'b1111;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
`ifdef RRMUX_LAST_LOCK_EN
    in_last = 4'b1111;
`endif
    @(posedge clk); #1 checkEn = 1'b1;

    repeat (2) begin
      @(negedge clk);
      checkOutput("reset in_ready", 32'(in_ready), 32'h0);
      checkOutput("reset out_valid", 32'(out_valid), 32'h0);
      checkOutput("reset out_sel", 32'(out_sel), 32'h0);
      checkOutput("reset out_data", 32'(out_data), 32'h0);
    end
    @(posedge clk); #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("first grant in_ready", 32'(in_ready), 32'h1);
    checkOutput("latency out_valid", 32'(out_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("fair out_valid", 32'(out_valid), 32'h1);
      checkOutput("fair out_sel", 32'(out_sel), 32'(i % 4));
      checkOutput("fair out_data", 32'(out_data), 32'(8'hA0 + i % 4));
    end

    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall out_sel", 32'(out_sel), 32'h0);
      checkOutput("stall out_data", 32'(out_data), 32'hA0);
      checkOutput("stall in_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain+load in_ready", 32'(in_ready), 32'h2);
    @(negedge clk);
    checkOutput("drain+load out_sel", 32'(out_sel), 32'h1);
    checkOutput("drain+load out_data", 32'(out_data), 32'hA1);

    in_valid = 4'b1000;
    @(posedge clk); #1 in_valid = 4'b1010;
    @(negedge clk);
    checkOutput("sparse setup out_sel", 32'(out_sel), 32'h3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("sparse out_sel", 32'(out_sel), 32'(sparseExp[i]));
    end

    @(posedge clk); #1 in_valid = 4'b0100;
    @(posedge clk); #1 begin rst = 1'b1; in_valid = 4'b1111; end
    @(negedge clk);
    checkOutput("pre-reset out_sel", 32'(out_sel), 32'h2);
    checkOutput("pre-reset out_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    checkOutput("mid reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("mid reset in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post reset in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    checkOutput("post reset out_sel", 32'(out_sel), 32'h0);

`ifdef RRMUX_LAST_LOCK_EN
    @(posedge clk); #1 begin rst = 1'b1; end
    @(posedge clk); #1 begin
      rst = 1'b0; in_valid = 4'b0110; in_last = 4'b0100;
      in_data = {8'hD3, 8'hD2, 8'hC0, 8'hD0};
    end
    @(posedge clk); #1 in_data[WIDTH +: WIDTH] = 8'hC1;
    @(negedge clk);
    checkOutput("lock beat0 sel", 32'(out_sel), 32'h1);
    checkOutput("lock beat0 last", 32'(out_last), 32'h0);
    @(posedge clk); #1 begin in_last[1] = 1'b1; in_data[WIDTH +: WIDTH] = 8'hC2; end
    @(negedge clk);
    checkOutput("lock beat1 sel", 32'(out_sel), 32'h1);
    checkOutput("lock beat1 data", 32'(out_data), 32'hC1);
    @(posedge clk); #1 in_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("lock beat2 sel", 32'(out_sel), 32'h1);
    checkOutput("lock beat2 last", 32'(out_last), 32'h1);
    @(negedge clk);
    checkOutput("lock release sel", 32'(out_sel), 32'h2);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1 applyStimulus();
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux4to1.md
# rr_mux4to1

Sequential 4-to-1 round-robin multiplexer with valid/ready handshakes. It merges four input streams into one output stream and tags each output beat with a 2-bit source index `out_sel`. `out_sel` uses the same encoding as the 1-to-4 demultiplexer's `sel`, so a link from this block back to the demux round-trips each beat to its original channel. It is the gather end of the demux path, for designs that funnel four producers into one shared consumer.

## Interface
- `WIDTH`, 8, data width of every channel
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `in_valid`  input  4  per-channel valid; bit i belongs to channel i
- `in_data`  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_ready`  output  4  per-channel ready, one-hot or zero
- `in_last`  input  4  end-of-packet marker per channel; present only with `RRMUX_LAST_LOCK_EN`
- `out_valid`  output  1  output register holds a beat
- `out_data`  output  WIDTH  registered data of the granted channel
- `out_sel`  output  2  index of the channel that produced `out_data`
- `out_last`  output  1  registered `in_last` of the granted beat; present only with `RRMUX_LAST_LOCK_EN`
- `out_ready`  input  1  consumer accepts the beat

## Operation
- The block has a single output register (valid, data, sel) and a 2-bit round-robin pointer `last_gnt`.
- `load = !out_valid | out_ready`. The register may take a new beat whenever `load` is true.
- Arbitration:
  - Search `in_valid` starting at index `(last_gnt+1) mod 4` and increasing with wrap-around.
  - The first set bit is the grant `g`.
  - If `in_valid` is 0, there is no grant.
- `in_ready[i] = load & grant_valid & (g == i)`. This is combinational from `out_ready` and `in_valid`. At most one bit is high.
- When a transfer happens on channel g:
  - next cycle `out_valid=1`, `out_data=in_data[g]`, `out_sel=g`
  - `last_gnt=g`
- If `load` is true and there is no grant, next cycle `out_valid=0`. `out_data` and `out_sel` hold their previous values.
- If `out_valid=1` and `out_ready=0`, all output registers hold and `in_ready` is 0.
- Arithmetic: the pointer increments mod 4. Data passes through unmodified with no width change.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=2'b00`, `out_last=0`, `last_gnt=2'b11`, so channel 0 wins first. `in_ready=0` while `rst=1`.
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 beat per cycle while `out_ready` stays high.
- Simultaneous drain and load in one cycle are legal: the old beat leaves and the new beat enters the register in the same edge.
- An input must not drop `in_valid` or change `in_data` while it is waiting. The block does not check this.
- Starvation bound: a channel that holds `in_valid` is granted within 4 output transfers.
- Reset mid-operation: a beat in the output register is discarded, the pointer returns to 3, and no `in_ready` is asserted in the reset cycle.

## Configuration
- `RRMUX_LAST_LOCK_EN` defined:
  - The `in_last` and `out_last` ports exist.
  - After a transfer from channel g with `in_last[g]=0`, the grant is locked to g.
  - While locked, no other channel gets `in_ready` and `last_gnt` does not advance, even if g drops `in_valid`.
  - The lock releases on the transfer of a beat with `in_last=1`; round-robin then resumes from g+1.
  - Reset clears the lock.
  - This keeps packets contiguous for the downstream demux.
- `RRMUX_LAST_LOCK_EN` undefined: the ports are absent and arbitration is per beat.

## Test plan
- Reset check: assert `rst` for 2 cycles with all `in_valid=4'b1111` -> `in_ready=0`, `out_valid=0`, `out_sel=0`, `out_data=0` throughout.
- Fairness: all four channels valid with data 8'hA0..8'hA3 and `out_ready=1` held -> output sequence `out_sel` 0,1,2,3,0..., data A0,A1,A2,A3, one beat per cycle, first beat 1 cycle after the first handshake.
- Backpressure: `out_ready=0` for 3 cycles while a beat is held -> `out_data` and `out_sel` stable, `in_ready=0`. Raise `out_ready` -> a new beat loads in the same cycle the old one drains.
- Sparse/wrap: only channels 3 and 1 valid after a grant to 3 -> grant order 1, 3, 1, 3; pointer wraps from 3 to 0 and channel 1 is found first.
- Reset mid-stream: assert `rst` while `out_valid=1` with `out_sel=2` -> next cycle `out_valid=0`. After release with all channels valid, the first grant is channel 0.
- With `RRMUX_LAST_LOCK_EN`: channel 1 sends 3 beats with last=0,0,1 while channel 2 is valid. Channel 2 is served only after the last=1 beat, and `out_last=1` appears on the third channel-1 beat.
